uart_tx_cfg: RTL and testbench

Parametrised UART transmitter that serialises one data word per valid/ready handshake onto a single TX line. Data width (5–9 bits), parity mode (none/even/odd) and stop-bit count (1/2) are set by parameters. The bit period is a fixed clock divisor. A `busy` status and a one-cycle `done` pulse let a host or FIFO front-end stream frames back-to-back.

---
 rtl/uart_tx_cfg_if.sv | 15 +
 rtl/uart_tx_cfg.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_cfg_if.sv
// Host-side word handshake for uart_tx_cfg.
//   valid : host presents a word on `in`
//   in    : DATA_BITS-wide word, LSB transmitted first
//   ready : transmitter can accept a word this cycle
// master = host/FIFO side, slave = transmitter side.
interface uart_tx_cfg_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 valid;
    logic [DATA_BITS-1:0] in;
    logic                 ready;

    modport master (output valid, output in, input ready);
    modport slave  (input valid, input in, output ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, DATA_BITS payload bits (LSB first),
// optional even/odd parity bit, STOP_BITS stop bits. Each bit lasts
// DIV = CLOCK_RATE/BAUD_RATE clock cycles.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   en    : transmit enable, gates acceptance of new frames only
//   host  : valid/in/ready word handshake (slave side)
//   out   : TX line, idles high, driven straight from a register
//   busy  : a frame is in progress
//   done  : one-cycle pulse when the final stop bit completes
module uart_tx_cfg #(
    parameter int unsigned CLOCK_RATE = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    uart_tx_cfg_if.slave  host,
    output logic          out,
    output logic          busy,
    output logic          done
);

    localparam int unsigned DIV   = CLOCK_RATE / BAUD_RATE;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_cfg: CLOCK_RATE/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     baud_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 ready_q;

    logic baud_end;
    assign baud_end   = (baud_q == CNT_W'(DIV - 1));
    assign host.ready = ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            ready_q <= 1'b0;
            out     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    out <= 1'b1;
                    if (en && host.valid && ready_q) begin
                        shift_q <= host.in;
                        // Parity is fixed at accept so the word need not be kept whole.
                        par_q   <= (^host.in) ^ (PARITY == 2);
                        ready_q <= 1'b0;
                        busy    <= 1'b1;
                        out     <= 1'b0;
                        baud_q  <= '0;
                        state_q <= StStart;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end

                StStart: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        out     <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end

                StData: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                            bit_q <= '0;
                            if (PARITY != 0) begin
                                out     <= par_q;
                                state_q <= StParity;
                            end else begin
                                out     <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            bit_q   <= bit_q + BIT_W'(1);
                            out     <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end

                StParity: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        out     <= 1'b1;
                        state_q <= StStop;
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end

                StStop: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        // bit_q counts stop bits here.
                        if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                            bit_q   <= '0;
                            ready_q <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= StIdle;
                    out     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three instances (8N1, 7E2, 8O1) at DIV = 4, checked
// cycle by cycle against a frame built from the UART framing rules.
module tb_uart_tx_cfg;

    localparam int unsigned CLK_RATE = 460800;
    localparam int unsigned BAUD     = 115200;
    localparam int unsigned DIV      = CLK_RATE / BAUD;

    int nb   [3] = '{8, 7, 8};
    int par  [3] = '{0, 1, 2};
    int stp  [3] = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] valid_v;
    logic [8:0] in_v [3];
    logic [2:0] out_v, busy_v, done_v, ready_v;

    int n_assert = 0;
    int n_fail   = 0;

    bit exp_bits[$];

    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_BITS(8)) if_8n1 ();
    uart_tx_cfg_if #(.DATA_BITS(7)) if_7e2 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if_8o1 ();

    assign if_8n1.valid = valid_v[0];
    assign if_8n1.in    = in_v[0][7:0];
    assign ready_v[0]   = if_8n1.ready;
    assign if_7e2.valid = valid_v[1];
    assign if_7e2.in    = in_v[1][6:0];
    assign ready_v[1]   = if_7e2.ready;
    assign if_8o1.valid = valid_v[2];
    assign if_8o1.in    = in_v[2][7:0];
    assign ready_v[2]   = if_8o1.ready;

    uart_tx_cfg #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1)) dut_8n1 (
        .clk(clk), .reset(reset), .en(en), .host(if_8n1),
        .out(out_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );
    uart_tx_cfg #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2)) dut_7e2 (
        .clk(clk), .reset(reset), .en(en), .host(if_7e2),
        .out(out_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );
    uart_tx_cfg #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1)) dut_8o1 (
        .clk(clk), .reset(reset), .en(en), .host(if_8o1),
        .out(out_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line levels of one frame, one entry per bit period.
    task automatic build_frame(int s, logic [8:0] data);
        int ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < nb[s]; i++) begin
            exp_bits.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (par[s] == 1) exp_bits.push_back(bit'(ones % 2));
        if (par[s] == 2) exp_bits.push_back(bit'(1 - ones % 2));
        for (int i = 0; i < stp[s]; i++) exp_bits.push_back(1'b1);
    endtask

    // Entered at the negedge right after the accept edge; returns at the done cycle.
    task automatic run_frame(int s, logic [8:0] data);
        int len;
        build_frame(s, data);
        len = exp_bits.size() * DIV;
        for (int k = 0; k < len; k++) begin
            chk($sformatf("s%0d d%0h out c%0d", s, data, k), 32'(out_v[s]),
                32'(exp_bits[k / DIV]));
            chk($sformatf("s%0d ready c%0d", s, k), 32'(ready_v[s]), 32'd0);
            chk($sformatf("s%0d busy c%0d", s, k), 32'(busy_v[s]), 32'd1);
            chk($sformatf("s%0d done c%0d", s, k), 32'(done_v[s]), 32'd0);
            @(negedge clk);
        end
        chk($sformatf("s%0d done pulse", s), 32'(done_v[s]), 32'd1);
        chk($sformatf("s%0d ready end", s), 32'(ready_v[s]), 32'd1);
        chk($sformatf("s%0d busy end", s), 32'(busy_v[s]), 32'd0);
        chk($sformatf("s%0d out end", s), 32'(out_v[s]), 32'd1);
    endtask

    task automatic send(int s, logic [8:0] data);
        chk($sformatf("s%0d ready before send", s), 32'(ready_v[s]), 32'd1);
        valid_v[s] = 1'b1;
        in_v[s]    = data;
        @(negedge clk);
        valid_v[s] = 1'b0;
        in_v[s]    = 9'($urandom);
        run_frame(s, data);
        @(negedge clk);
        chk($sformatf("s%0d done one cycle", s), 32'(done_v[s]), 32'd0);
    endtask

    task automatic idle_check(string tag, int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            chk({tag, " ready"}, 32'(ready_v[0]), 32'd1);
            chk({tag, " out"}, 32'(out_v[0]), 32'd1);
            chk({tag, " busy"}, 32'(busy_v[0]), 32'd0);
            chk({tag, " done"}, 32'(done_v[0]), 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] w;
        reset   = 1'b1;
        en      = 1'b0;
        valid_v = '0;
        for (int s = 0; s < 3; s++) in_v[s] = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("s%0d reset out", s), 32'(out_v[s]), 32'd1);
            chk($sformatf("s%0d reset ready", s), 32'(ready_v[s]), 32'd0);
            chk($sformatf("s%0d reset busy", s), 32'(busy_v[s]), 32'd0);
            chk($sformatf("s%0d reset done", s), 32'(done_v[s]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("s%0d ready after release", s), 32'(ready_v[s]), 32'd1);
            chk($sformatf("s%0d out after release", s), 32'(out_v[s]), 32'd1);
        end
        en = 1'b1;

        // Directed frames.
        send(0, 9'h0A5);
        send(1, 9'h035);
        send(2, 9'h0FF);

        // Back-to-back with valid held high.
        valid_v[0] = 1'b1;
        in_v[0]    = 9'h001;
        @(negedge clk);
        in_v[0] = 9'h080;
        run_frame(0, 9'h001);
        @(negedge clk);
        valid_v[0] = 1'b0;
        in_v[0]    = 9'($urandom);
        run_frame(0, 9'h080);
        @(negedge clk);
        chk("b2b done one cycle", 32'(done_v[0]), 32'd0);

        // Reset during data bit 3 (cycles 16..19 after accept).
        valid_v[0] = 1'b1;
        in_v[0]    = 9'h0C3;
        @(negedge clk);
        valid_v[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre-reset out bit3", 32'(out_v[0]), 32'd0);
        chk("pre-reset busy", 32'(busy_v[0]), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async reset out", 32'(out_v[0]), 32'd1);
        chk("async reset ready", 32'(ready_v[0]), 32'd0);
        chk("async reset busy", 32'(busy_v[0]), 32'd0);
        chk("async reset done", 32'(done_v[0]), 32'd0);
        @(negedge clk);
        chk("held reset out", 32'(out_v[0]), 32'd1);
        chk("held reset ready", 32'(ready_v[0]), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset ready", 32'(ready_v[0]), 32'd1);
        chk("post-reset done", 32'(done_v[0]), 32'd0);
        chk("post-reset busy", 32'(busy_v[0]), 32'd0);
        send(0, 9'h05A);

        // en low: valid ignored.
        en         = 1'b0;
        valid_v[0] = 1'b1;
        in_v[0]    = 9'h03C;
        idle_check("en low", 8);
        valid_v[0] = 1'b0;
        en         = 1'b1;
        @(negedge clk);

        // en dropped mid-frame: frame completes, no further accept.
        valid_v[0] = 1'b1;
        in_v[0]    = 9'h096;
        @(negedge clk);
        en      = 1'b0;
        in_v[0] = 9'($urandom);
        run_frame(0, 9'h096);
        idle_check("en dropped", 8);
        valid_v[0] = 1'b0;
        en         = 1'b1;
        @(negedge clk);

        // Random words on every configuration.
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 3; s++) begin
                w = 9'($urandom_range(0, (1 << nb[s]) - 1));
                send(s, w);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
